// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer wrapped around a combinational 8-bit ALU.
// Three-cycle IDLE -> EXEC -> WB loop with a small internal register file.
module alu_issue_ctrl #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_op,
    input  logic [7:0]    alu_result,
    input  logic          alu_carry,
    output logic          done,
    output logic [7:0]    done_result,
    output logic          carry_flag
);

    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t        state;
    logic [7:0]    regs [NREG];
    logic [AW-1:0] rd_q;
    logic [7:0]    res_q;

    assign instr_ready = (state == IDLE);
    assign rd_data     = regs[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
            rd_q        <= '0;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_op      <= 4'h0;
            res_q       <= 8'h00;
            done        <= 1'b0;
            done_result <= 8'h00;
            carry_flag  <= 1'b0;
        end else begin
            // Host write first so a same-edge writeback to the same address overrides it
            if (wr_en) regs[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_a  <= regs[instr_rs1];
                        alu_b  <= regs[instr_rs2];
                        alu_op <= instr_op;
                        rd_q   <= instr_rd;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    carry_flag  <= alu_carry;
                    done        <= 1'b1;
                    done_result <= alu_result;
                    state       <= WB;
                end
                WB: begin
                    regs[rd_q] <= res_q;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder standing in for the ALU.
// Expected results are queued at issue and popped whenever done pulses.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       done;
    logic [7:0] done_result;
    logic       carry_flag;

    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    logic [8:0] exp_q [$];
    logic [7:0] mregs [4];

    always #5 clk = ~clk;

    assign {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_issue_ctrl #(.AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .done(done), .done_result(done_result), .carry_flag(carry_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one edge, sample at the falling edge, score any completion.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_spurious", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_result", {24'd0, done_result}, {24'd0, e[7:0]});
                check("carry_flag", {31'd0, carry_flag}, {31'd0, e[8]});
            end
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = i[1:0];
            #1;
            check(tag, {24'd0, rd_data}, {24'd0, mregs[i]});
        end
    endtask

    task automatic hwrite(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        mregs[a] = d;
    endtask

    // Single instruction; optional host write lands on the WB edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic hw_en, input logic [1:0] hw_addr,
                         input logic [7:0] hw_data);
        logic [7:0] a, b;
        logic [8:0] e;
        a = mregs[rs1];
        b = mregs[rs2];
        e = {1'b0, a} + {1'b0, b};
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        exp_q.push_back(e);
        tick();
        instr_valid = 1'b0;
        instr_op = 4'($urandom); instr_rd = 2'($urandom);
        instr_rs1 = 2'($urandom); instr_rs2 = 2'($urandom);
        check("ready_exec", {31'd0, instr_ready}, 32'd0);
        check("done_exec", {31'd0, done}, 32'd0);
        check("alu_a", {24'd0, alu_a}, {24'd0, a});
        check("alu_b", {24'd0, alu_b}, {24'd0, b});
        check("alu_op", {28'd0, alu_op}, {28'd0, op});
        tick();
        check("done_wb", {31'd0, done}, 32'd1);
        if (hw_en) begin
            wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
        end
        tick();
        wr_en = 1'b0;
        check("done_after", {31'd0, done}, 32'd0);
        check("ready_after", {31'd0, instr_ready}, 32'd1);
        check("done_result_hold", {24'd0, done_result}, {24'd0, e[7:0]});
        check("carry_hold", {31'd0, carry_flag}, {31'd0, e[8]});
        check("alu_op_hold", {28'd0, alu_op}, {28'd0, op});
        if (hw_en) mregs[hw_addr] = hw_data;
        mregs[rd] = e[7:0];
    endtask

    initial begin
        logic [3:0] last_op;
        logic [3:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [8:0] e;
        int         d0;

        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;

        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            instr_valid = 1'($urandom); instr_op = 4'($urandom);
            instr_rd = 2'($urandom); instr_rs1 = 2'($urandom); instr_rs2 = 2'($urandom);
            wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = 8'($urandom);
            tick();
        end
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_alu_a", {24'd0, alu_a}, 32'd0);
        check("rst_alu_b", {24'd0, alu_b}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_done_result", {24'd0, done_result}, 32'd0);
        check("rst_carry", {31'd0, carry_flag}, 32'd0);
        check_regs("rst_regs");
        instr_valid = 1'b0; wr_en = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic add
        hwrite(2'd1, 8'h33);
        hwrite(2'd2, 8'hCC);
        issue(4'h0, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_regs("basic_regs");

        // Carry, then dependent instruction issued on the next possible edge
        hwrite(2'd0, 8'h01);
        issue(4'h1, 2'd3, 2'd3, 2'd0, 1'b0, 2'd0, 8'h00);
        issue(4'h2, 2'd2, 2'd3, 2'd3, 1'b0, 2'd0, 8'h00);
        check_regs("dep_regs");

        // Back-to-back with valid held high
        hwrite(2'd1, 8'h90);
        hwrite(2'd2, 8'h7F);
        d0 = done_cnt;
        last_op = alu_op;
        for (int i = 0; i < 9; i++) begin
            op = 4'(i + 5); rd = 2'($urandom_range(0, 3));
            rs1 = 2'($urandom_range(0, 3)); rs2 = 2'($urandom_range(0, 3));
            instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
            check("b2b_ready", {31'd0, instr_ready}, {31'd0, (i % 3 == 0)});
            if (i % 3 == 0) begin
                e = {1'b0, mregs[rs1]} + {1'b0, mregs[rs2]};
                exp_q.push_back(e);
                mregs[rd] = e[7:0];
                last_op = op;
            end
            tick();
            check("b2b_alu_op", {28'd0, alu_op}, {28'd0, last_op});
        end
        instr_valid = 1'b0;
        tick();
        tick();
        check("b2b_done_count", done_cnt - d0, 32'd3);
        check_regs("b2b_regs");

        // Host write colliding with writeback: same address, then different address
        hwrite(2'd1, 8'h33);
        hwrite(2'd2, 8'hCC);
        issue(4'h3, 2'd0, 2'd1, 2'd2, 1'b1, 2'd0, 8'hAA);
        check_regs("coll_same");
        issue(4'h4, 2'd3, 2'd1, 2'd1, 1'b1, 2'd2, 8'hAA);
        check_regs("coll_diff");

        // Reset one cycle after acceptance aborts the instruction
        instr_valid = 1'b1; instr_op = 4'h7; instr_rd = 2'd0; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        tick();
        instr_valid = 1'b0;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        check("abort_ready", {31'd0, instr_ready}, 32'd1);
        check("abort_alu_a", {24'd0, alu_a}, 32'd0);
        tick();
        tick();
        check("abort_no_done", done_cnt - d0, 32'd0);
        check_regs("abort_regs");
        rst_n = 1'b1;
        tick();
        hwrite(2'd1, 8'h10);
        hwrite(2'd2, 8'h20);
        issue(4'h8, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_regs("post_abort_regs");
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
